// File: rtl/seq_divider_if.sv
// seq_divider_if: handshake bundle for the sequential divider.
//   Request side : in_valid, in_ready, dividend, divisor
//   Response side: out_valid, out_ready, quotient, remainder, div_by_zero
// The master modport belongs to the block that supplies operands and consumes
// results. The slave modport belongs to the divider.
interface seq_divider_if #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset
//   io      - seq_divider_if.slave. Operands arrive with a valid/ready handshake.
//             Results are returned with a valid/ready handshake that carries
//             quotient, remainder and div_by_zero.
// A zero divisor completes at once. The quotient is all ones, the remainder is
// the low dividend bits, and div_by_zero is set.
module seq_divider #(
  parameter int DIVIDEND_W = 32,
  parameter int DIVISOR_W  = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  seq_divider_if.slave   io
);
  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e                state_q, state_d;
  // work register: remaining dividend bits leave at the MSB, and quotient bits enter at the LSB
  logic [DIVIDEND_W-1:0] work_q, work_d;
  logic [DIVISOR_W-1:0]  divisor_q, divisor_d;
  logic [DIVISOR_W:0]    prem_q, prem_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]  remainder_q, remainder_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W+1:0]  rem_tmp;
  logic [DIVISOR_W+1:0]  diff;
  logic                  qbit;
  logic [DIVISOR_W:0]    prem_next;

  // One restoring step. rem_tmp is always below 2*divisor, so the top bit of
  // the difference is a true borrow: no borrow means rem_tmp >= divisor.
  always_comb begin
    rem_tmp   = {prem_q, work_q[DIVIDEND_W-1]};
    diff      = rem_tmp - {2'b00, divisor_q};
    qbit      = ~diff[DIVISOR_W+1];
    prem_next = qbit ? diff[DIVISOR_W:0] : rem_tmp[DIVISOR_W:0];
  end

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    divisor_d   = divisor_q;
    prem_d      = prem_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    unique case (state_q)
      IDLE: begin
        if (io.in_valid) begin
          work_d    = io.dividend;
          divisor_d = io.divisor;
          prem_d    = '0;
          if (io.divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = io.dividend[DIVISOR_W-1:0];
            dbz_d       = 1'b1;
          end else begin
            state_d = CALC;
            count_d = CNT_W'(DIVIDEND_W);
          end
        end
      end
      CALC: begin
        work_d  = {work_q[DIVIDEND_W-2:0], qbit};
        prem_d  = prem_next;
        count_d = count_q - CNT_W'(1);
        if (count_q == CNT_W'(1)) begin
          state_d     = DONE;
          quotient_d  = {work_q[DIVIDEND_W-2:0], qbit};
          // The remainder is always below the divisor, so its top bit is zero.
          remainder_d = prem_next[DIVISOR_W-1:0];
          dbz_d       = 1'b0;
        end
      end
      DONE: begin
        if (io.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      work_q      <= '0;
      divisor_q   <= '0;
      prem_q      <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      divisor_q   <= divisor_d;
      prem_q      <= prem_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign io.in_ready    = (state_q == IDLE);
  assign io.out_valid   = (state_q == DONE);
  assign io.quotient    = quotient_q;
  assign io.remainder   = remainder_q;
  assign io.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;
  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  seq_divider_if #(.DIVIDEND_W(32), .DIVISOR_W(16)) dif ();

  seq_divider #(.DIVIDEND_W(32), .DIVISOR_W(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents one operation, waits for acceptance and then for out_valid.
  // lat is the number of edges after the accepting edge at which out_valid is first seen.
  task automatic start_op(input logic [31:0] dvd, input logic [15:0] dvs, output int lat);
    @(negedge clk);
    dif.in_valid = 1'b1;
    dif.dividend = dvd;
    dif.divisor  = dvs;
    @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
    lat = 0;
    while (dif.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic finish_op(input string tag);
    @(negedge clk);
    dif.out_ready = 1'b1;
    @(posedge clk);
    #1;
    dif.out_ready = 1'b0;
    check({tag, "_ovld_clr"}, {63'd0, dif.out_valid}, 64'd0);
    check({tag, "_irdy_set"}, {63'd0, dif.in_ready}, 64'd1);
  endtask

  task automatic run_directed(input string tag, input logic [31:0] dvd, input logic [15:0] dvs,
                              input logic [31:0] exp_q, input logic [15:0] exp_r,
                              input logic exp_dbz, input int exp_lat);
    int lat;
    start_op(dvd, dvs, lat);
    check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check({tag, "_q"}, {32'd0, dif.quotient}, {32'd0, exp_q});
    check({tag, "_r"}, {48'd0, dif.remainder}, {48'd0, exp_r});
    check({tag, "_dbz"}, {63'd0, dif.div_by_zero}, {63'd0, exp_dbz});
    finish_op(tag);
  endtask

  logic [31:0] seeds [5] = '{32'd1, 32'd42, 32'd1234, 32'd99991, 32'd7};

  initial begin
    int          lat;
    logic [31:0] dvd;
    logic [15:0] dvs;
    logic [63:0] recon;
    n_tests      = 0;
    n_fail       = 0;
    reset_n      = 1'b0;
    dif.in_valid = 1'b0;
    dif.out_ready = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", {63'd0, dif.in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, dif.out_valid}, 64'd0);
    check("rst_quotient", {32'd0, dif.quotient}, 64'd0);
    check("rst_remainder", {48'd0, dif.remainder}, 64'd0);
    check("rst_dbz", {63'd0, dif.div_by_zero}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    run_directed("d100_7", 32'd100, 16'd7, 32'd14, 16'd2, 1'b0, 32);
    run_directed("dmax", 32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 16'h0000, 1'b0, 32);
    run_directed("dby1", 32'h1234_5678, 16'd1, 32'h1234_5678, 16'h0000, 1'b0, 32);
    run_directed("dz", 32'hDEAD_BEEF, 16'd0, 32'hFFFF_FFFF, 16'hBEEF, 1'b1, 0);

    // Backpressure: result held while out_ready is low, new requests are ignored.
    start_op(32'd50, 16'd5, lat);
    check("bp_lat", 64'(lat), 64'd32);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      dif.in_valid = 1'b1;
      dif.dividend = 32'd77;
      dif.divisor  = 16'd0;
      @(posedge clk);
      #1;
      check("bp_ovld", {63'd0, dif.out_valid}, 64'd1);
      check("bp_irdy", {63'd0, dif.in_ready}, 64'd0);
      check("bp_q", {32'd0, dif.quotient}, 64'd10);
      check("bp_r", {48'd0, dif.remainder}, 64'd0);
      check("bp_dbz", {63'd0, dif.div_by_zero}, 64'd0);
    end
    @(negedge clk);
    dif.in_valid = 1'b0;
    finish_op("bp");
    repeat (2) @(posedge clk);
    #1;
    check("bp_idle_irdy", {63'd0, dif.in_ready}, 64'd1);
    check("bp_idle_hold_q", {32'd0, dif.quotient}, 64'd10);

    // Reset pulse part-way through 1000/3.
    @(negedge clk);
    dif.in_valid = 1'b1;
    dif.dividend = 32'd1000;
    dif.divisor  = 16'd3;
    @(posedge clk);
    #1;
    dif.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("mrst_irdy", {63'd0, dif.in_ready}, 64'd1);
    check("mrst_ovld", {63'd0, dif.out_valid}, 64'd0);
    check("mrst_q", {32'd0, dif.quotient}, 64'd0);
    check("mrst_r", {48'd0, dif.remainder}, 64'd0);
    check("mrst_dbz", {63'd0, dif.div_by_zero}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_directed("d1000_3", 32'd1000, 16'd3, 32'd333, 16'd1, 1'b0, 32);

    // Back-to-back pseudo-random operations from fixed seeds.
    for (int s = 0; s < 5; s++) begin
      void'($urandom(seeds[s]));
      for (int k = 0; k < 4; k++) begin
        dvd = $urandom;
        dvs = (k % 2 == 0) ? 16'($urandom_range(1, 255)) : 16'($urandom_range(1, 65535));
        start_op(dvd, dvs, lat);
        check("rnd_lat", 64'(lat), 64'd32);
        recon = {32'd0, dif.quotient} * {48'd0, dvs} + {48'd0, dif.remainder};
        check("rnd_identity", recon, {32'd0, dvd});
        check("rnd_rem_lt", {63'd0, (dif.remainder < dvs)}, 64'd1);
        check("rnd_q", {32'd0, dif.quotient}, {32'd0, dvd / {16'd0, dvs}});
        check("rnd_dbz", {63'd0, dif.div_by_zero}, 64'd0);
        finish_op("rnd");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
